// File: rtl/param_updown_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter_if
// Brief    : Control/status bundle between a counter and its controller.
// Revision : 1.0 - initial release
// ============================================================================
interface param_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             clr_ovf;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (
    output en, up, load, din, clr_ovf,
    input  q, tc, wrap, ovf
  );

  modport slave (
    input  en, up, load, din, clr_ovf,
    output q, tc, wrap, ovf
  );
endinterface
`default_nettype wire

// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Brief    : Synchronous modulo-MOD up/down counter with load, wrap/saturate,
//            terminal count, wrap pulse and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MOD      = 16,
  parameter int SATURATE = 0
) (
  input  wire clk,
  input  wire reset,
  param_updown_counter_if.slave bus
);

  generate
    if ((MOD < 2) || (longint'(MOD) > (longint'(1) << WIDTH))) begin : g_bad_mod
      $error("param_updown_counter: MOD=%0d illegal for WIDTH=%0d", MOD, WIDTH);
    end
  endgenerate

  localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   c_mod_ext = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             ovf_q,   ovf_d;

  logic             w_at_max;
  logic             w_at_min;
  logic             w_tc;
  logic             w_bound;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_up_bound;
  logic [WIDTH-1:0] w_dn_bound;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;

  assign w_at_max = (count_q == c_max_val);
  assign w_at_min = (count_q == '0);
  assign w_tc     = bus.en & (bus.up ? w_at_max : w_at_min);
  assign w_bound  = w_tc & ~bus.load;

  // Clamp out-of-range loads so q can never leave 0..MOD-1.
  assign w_load_val = ({1'b0, bus.din} >= c_mod_ext) ? c_max_val : bus.din;

  generate
    if (SATURATE != 0) begin : g_saturate
      assign w_up_bound = c_max_val;
      assign w_dn_bound = '0;
    end else begin : g_wrap
      assign w_up_bound = '0;
      assign w_dn_bound = c_max_val;
    end
  endgenerate

  assign w_inc = w_at_max ? w_up_bound : count_q + WIDTH'(1);
  assign w_dec = w_at_min ? w_dn_bound : count_q - WIDTH'(1);

  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = w_load_val;
    end else if (bus.en) begin
      count_d = bus.up ? w_inc : w_dec;
    end
  end

  // A bound event sets ovf even when clr_ovf is asserted on the same edge.
  assign wrap_d = w_bound;
  assign ovf_d  = w_bound | (ovf_q & ~bus.clr_ovf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.q    = count_q;
  assign bus.tc   = w_tc;
  assign bus.wrap = wrap_q;
  assign bus.ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Brief    : Scoreboard bench: wrap, down, saturate, load clamp, async reset
//            and an 8-bit cascade of two counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       tc;
    logic       wrap;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  event sb_kick;
  int   n_checks = 0;
  int   n_errors = 0;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  param_updown_counter_if #(.WIDTH(4)) if_a  ();
  param_updown_counter_if #(.WIDTH(4)) if_b  ();
  param_updown_counter_if #(.WIDTH(4)) if_c  ();
  param_updown_counter_if #(.WIDTH(4)) if_lo ();
  param_updown_counter_if #(.WIDTH(4)) if_hi ();

  param_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) dut_a  (.clk(clk), .reset(reset), .bus(if_a));
  param_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut_b  (.clk(clk), .reset(reset), .bus(if_b));
  param_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) dut_c  (.clk(clk), .reset(reset), .bus(if_c));
  param_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) dut_lo (.clk(clk), .reset(reset), .bus(if_lo));
  param_updown_counter #(.WIDTH(4), .MOD(16), .SATURATE(0)) dut_hi (.clk(clk), .reset(reset), .bus(if_hi));

  assign if_hi.en = if_lo.tc;

  // id 0: MOD16 wrap, 1: MOD10 wrap, 2: MOD10 saturate, 3: {hi,lo} cascade
  function automatic logic tc_model(input int id, input logic [7:0] q, input logic en, input logic up);
    logic [3:0] lim;
    lim = (id == 1 || id == 2) ? 4'd9 : 4'd15;
    return en & (up ? (q[3:0] == lim) : (q[3:0] == 4'd0));
  endfunction

  task automatic drive(input int id, input logic en, input logic up, input logic load,
                       input logic [3:0] din, input logic clr);
    case (id)
      0: begin if_a.en = en; if_a.up = up; if_a.load = load; if_a.din = din; if_a.clr_ovf = clr; end
      1: begin if_b.en = en; if_b.up = up; if_b.load = load; if_b.din = din; if_b.clr_ovf = clr; end
      2: begin if_c.en = en; if_c.up = up; if_c.load = load; if_c.din = din; if_c.clr_ovf = clr; end
      default: begin
        if_lo.en = en; if_lo.up = up; if_lo.load = load; if_lo.din = din; if_lo.clr_ovf = clr;
        if_hi.up = up; if_hi.load = 1'b0; if_hi.din = 4'h0; if_hi.clr_ovf = 1'b0;
      end
    endcase
  endtask

  task automatic sample(input int id, output logic [7:0] q, output logic tc,
                        output logic wrap, output logic ovf);
    case (id)
      0: begin q = {4'h0, if_a.q}; tc = if_a.tc; wrap = if_a.wrap; ovf = if_a.ovf; end
      1: begin q = {4'h0, if_b.q}; tc = if_b.tc; wrap = if_b.wrap; ovf = if_b.ovf; end
      2: begin q = {4'h0, if_c.q}; tc = if_c.tc; wrap = if_c.wrap; ovf = if_c.ovf; end
      default: begin q = {if_hi.q, if_lo.q}; tc = if_lo.tc; wrap = if_hi.wrap; ovf = if_hi.ovf; end
    endcase
  endtask

  task automatic push_exp(input int id, input logic [7:0] eq, input logic et,
                          input logic ew, input logic eo, input string name);
    exp_t e;
    e.id = id; e.q = eq; e.tc = et; e.wrap = ew; e.ovf = eo; e.name = name;
    sb.push_back(e);
  endtask

  // Drive inputs mid-low-phase, let one edge consume them, queue the post-edge state.
  task automatic step(input int id, input logic en, input logic up, input logic load,
                      input logic [3:0] din, input logic clr,
                      input logic [7:0] eq, input logic ew, input logic eo, input string name);
    @(negedge clk); #1;
    drive(id, en, up, load, din, clr);
    @(posedge clk); #1;
    push_exp(id, eq, tc_model(id, eq, en, up), ew, eo, name);
  endtask

  exp_t       m_e;
  logic [7:0] m_q;
  logic       m_tc, m_wrap, m_ovf;

  always begin
    @(negedge clk or sb_kick);
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      sample(m_e.id, m_q, m_tc, m_wrap, m_ovf);
      n_checks++;
      if ({m_q, m_tc, m_wrap, m_ovf} !== {m_e.q, m_e.tc, m_e.wrap, m_e.ovf}) begin
        n_errors++;
        $display("FAIL %s: got q=%0d tc=%0b wrap=%0b ovf=%0b, expected q=%0d tc=%0b wrap=%0b ovf=%0b",
                 m_e.name, m_q, m_tc, m_wrap, m_ovf, m_e.q, m_e.tc, m_e.wrap, m_e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int id = 0; id < 4; id++) drive(id, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    for (int id = 0; id < 4; id++) push_exp(id, 8'd0, 1'b0, 1'b0, 1'b0, "reset_state");
    -> sb_kick;
    @(negedge clk); #1;
    reset = 1'b0;

    // Default counter: full wrap-around
    for (int i = 1; i <= 17; i++)
      step(0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'(i % 16), (i == 16), (i >= 16), $sformatf("t1_up%0d", i));
    step(0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'd1, 1'b0, 1'b1, "t1_hold");
    step(0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 8'd1, 1'b0, 1'b0, "t1_clr_ovf");

    // MOD10 down-count from reset, then tc at zero
    step(1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd9, 1'b1, 1'b1, "t2_dn_wrap");
    step(1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd8, 1'b0, 1'b1, "t2_dn8");
    step(1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd7, 1'b0, 1'b1, "t2_dn7");
    step(1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'd1, 1'b0, 1'b1, "t2_load1");
    step(1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 1'b1, "t2_dn0_tc");
    step(1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd9, 1'b1, 1'b1, "t2_dn_wrap2");

    // MOD10 load clamp and load-over-count priority
    step(1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 8'd9, 1'b0, 1'b0, "t4_clr");
    step(1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd2, 1'b0, 1'b0, "t4_load2");
    step(1, 1'b0, 1'b1, 1'b1, 4'hA, 1'b0, 8'd9, 1'b0, 1'b0, "t4_clampA");
    step(1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 8'd2, 1'b0, 1'b0, "t4_load2b");
    step(1, 1'b0, 1'b1, 1'b1, 4'hC, 1'b0, 8'd9, 1'b0, 1'b0, "t4_clampC");
    step(1, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0, 8'd3, 1'b0, 1'b0, "t4_load_over_en");
    step(1, 1'b0, 1'b1, 1'b1, 4'd9, 1'b0, 8'd9, 1'b0, 1'b0, "t4_load9");
    step(1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'd9, 1'b0, 1'b0, "t4_idle");

    // MOD10 saturating
    for (int i = 1; i <= 12; i++)
      step(2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, (i >= 9) ? 8'd9 : 8'(i), (i >= 10), (i >= 10),
           $sformatf("t3_sat%0d", i));
    step(2, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 8'd9, 1'b1, 1'b1, "t3_set_beats_clr");
    step(2, 1'b0, 1'b1, 1'b0, 4'h0, 1'b1, 8'd9, 1'b0, 1'b0, "t3_clr");
    step(2, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0, 1'b0, "t3_load0");
    step(2, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b1, 1'b1, "t3_sat_low");
    step(2, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0, 1'b1, "t3_idle");

    // Async reset mid-count, resume, then direction flip
    step(0, 1'b0, 1'b1, 1'b1, 4'd14, 1'b0, 8'd14, 1'b0, 1'b0, "t5_load14");
    for (int i = 1; i <= 8; i++)
      step(0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'((14 + i) % 16), (i == 2), (i >= 2), $sformatf("t5_up%0d", i));
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    push_exp(0, 8'd0, 1'b0, 1'b0, 1'b0, "t5_async_reset");
    -> sb_kick;
    @(negedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    push_exp(0, 8'd1, 1'b0, 1'b0, 1'b0, "t5_resume1");
    for (int i = 2; i <= 5; i++)
      step(0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'(i), 1'b0, 1'b0, $sformatf("t5_resume%0d", i));
    step(0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd4, 1'b0, 1'b0, "t5_flip_down");
    step(0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd4, 1'b0, 1'b0, "t5_idle");

    // Cascade: combined {hi,lo} must track 0..255 and wrap
    for (int i = 1; i <= 257; i++)
      step(3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 8'(i % 256), (i == 256), (i >= 256), $sformatf("t6_up%0d", i));
    step(3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd0,   1'b0, 1'b1, "t6_down0");
    step(3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 8'd255, 1'b1, 1'b1, "t6_down_wrap");
    step(3, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'd255, 1'b0, 1'b1, "t6_idle");

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
